// File: rtl/pc_pkg.sv
// rtl/pc_pkg.sv - shared defaults and state encoding for the program-counter sequencer
package pc_pkg;

   // Default program-counter / jump-target width and first fetch address after Start.
   localparam int PC_W_DEF       = 12;
   localparam int START_ADDR_DEF = 0;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } pc_state_e;

endpackage

// File: rtl/pc_next.sv
// rtl/pc_next.sv - combinational next-ProgCtr selection while the sequencer is running
//
// Purpose: picks the next fetch address from the prioritised RUN-state controls.
// Optional feature macro: CALL_RET_EN (adds call/return through a one-deep link register).
// Ports:
//   pc_i        current ProgCtr
//   jump_i      target from the external jump lookup table
//   stall_i     hold everything this cycle
//   halt_i      halt instruction (PC holds; the state change is done by the caller)
//   branch_en_i decoded branch instruction
//   cond_i      ALU condition flag
//   call_en_i   call instruction            (CALL_RET_EN only)
//   ret_en_i    return instruction          (CALL_RET_EN only)
//   link_i      current link register value (CALL_RET_EN only)
//   link_nxt_o  next link register value    (CALL_RET_EN only)
//   pc_nxt_o    next ProgCtr
module pc_next #(
   parameter int PC_W = 12
) (
   input  logic [PC_W-1:0] pc_i,
   input  logic [PC_W-1:0] jump_i,
   input  logic            stall_i,
   input  logic            halt_i,
   input  logic            branch_en_i,
   input  logic            cond_i,
`ifdef CALL_RET_EN
   input  logic            call_en_i,
   input  logic            ret_en_i,
   input  logic [PC_W-1:0] link_i,
   output logic [PC_W-1:0] link_nxt_o,
`endif
   output logic [PC_W-1:0] pc_nxt_o
);

   logic [PC_W-1:0] pc_inc;

   // Plain binary add: all-ones naturally wraps to zero.
   assign pc_inc = pc_i + PC_W'(1);

   always_comb begin
      pc_nxt_o = pc_i;
`ifdef CALL_RET_EN
      link_nxt_o = link_i;
`endif
      if (stall_i || halt_i) begin
         pc_nxt_o = pc_i;
      end
`ifdef CALL_RET_EN
      else if (call_en_i) begin
         link_nxt_o = pc_inc;
         pc_nxt_o   = jump_i;
      end
      else if (ret_en_i) begin
         pc_nxt_o = link_i;
      end
`endif
      else if (branch_en_i && cond_i) begin
         pc_nxt_o = jump_i;
      end
      else begin
         pc_nxt_o = pc_inc;
      end
   end

endmodule

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - IDLE/RUN/DONE program-counter sequencer with jump-table branching
//
// Purpose: generates the fetch address for a small microcoded engine.
// Optional feature macro: CALL_RET_EN (call/return via a one-deep link register).
// Ports:
//   Clk       clock, rising-edge state updates
//   Reset     asynchronous active-high reset
//   Start     one-cycle pulse, starts (or restarts from DONE) execution
//   Halt      halt instruction
//   Stall     freeze the sequencer for the cycle
//   BranchEn  branch instruction; taken when Cond is also high
//   Cond      ALU condition flag
//   JptrIn    jump-table index from the instruction
//   Jump      target returned by the jump lookup table
//   CallEn    call instruction   (ignored unless CALL_RET_EN)
//   RetEn     return instruction (ignored unless CALL_RET_EN)
//   Jptr      index to the jump lookup table (combinational copy of JptrIn)
//   ProgCtr   current fetch address
//   Done      registered, high while halted
module pc_sequencer
   import pc_pkg::*;
#(
   parameter int              PC_W       = PC_W_DEF,
   parameter logic [PC_W-1:0] START_ADDR = PC_W'(START_ADDR_DEF)
) (
   input  logic            Clk,
   input  logic            Reset,
   input  logic            Start,
   input  logic            Halt,
   input  logic            Stall,
   input  logic            BranchEn,
   input  logic            Cond,
   input  logic [4:0]      JptrIn,
   input  logic [PC_W-1:0] Jump,
   input  logic            CallEn,
   input  logic            RetEn,
   output logic [4:0]      Jptr,
   output logic [PC_W-1:0] ProgCtr,
   output logic            Done
);

   pc_state_e       state_q, state_d;
   logic [PC_W-1:0] pc_q, pc_d;
   logic            done_q, done_d;
   logic [PC_W-1:0] pc_run;

`ifdef CALL_RET_EN
   logic [PC_W-1:0] link_q, link_d, link_run;
`else
   logic            unused_call_ret;
   assign unused_call_ret = CallEn ^ RetEn;
`endif

   // The lookup table is external and combinational, so its target is usable this cycle.
   assign Jptr    = JptrIn;
   assign ProgCtr = pc_q;
   assign Done    = done_q;

   pc_next #(
      .PC_W        (PC_W)
   ) u_pc_next (
      .pc_i        (pc_q),
      .jump_i      (Jump),
      .stall_i     (Stall),
      .halt_i      (Halt),
      .branch_en_i (BranchEn),
      .cond_i      (Cond),
`ifdef CALL_RET_EN
      .call_en_i   (CallEn),
      .ret_en_i    (RetEn),
      .link_i      (link_q),
      .link_nxt_o  (link_run),
`endif
      .pc_nxt_o    (pc_run)
   );

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      done_d  = done_q;
`ifdef CALL_RET_EN
      link_d  = link_q;
`endif
      case (state_q)
         IDLE: begin
            if (Start) begin
               pc_d    = START_ADDR;
               state_d = RUN;
            end
         end
         RUN: begin
            pc_d = pc_run;
`ifdef CALL_RET_EN
            link_d = link_run;
`endif
            if (!Stall && Halt) begin
               state_d = DONE;
               done_d  = 1'b1;
            end
         end
         DONE: begin
            if (Start) begin
               pc_d    = START_ADDR;
               done_d  = 1'b0;
               state_d = RUN;
            end
         end
         default: begin
            state_d = IDLE;
            pc_d    = START_ADDR;
            done_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state_q <= IDLE;
         pc_q    <= START_ADDR;
         done_q  <= 1'b0;
`ifdef CALL_RET_EN
         link_q  <= '0;
`endif
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         done_q  <= done_d;
`ifdef CALL_RET_EN
         link_q  <= link_d;
`endif
      end
   end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 SHALL have parameter PC_W, default 12, program-counter and jump-target width.
REQ-002 SHALL have parameter START_ADDR, default 0, first fetch address after Start.
REQ-003 SHALL have port Clk  input  1  single clock, all state updates on rising edge.
REQ-004 SHALL have port Reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port Start  input  1  one-cycle pulse that begins program execution.
REQ-006 SHALL have port Halt  input  1  decoded halt instruction.
REQ-007 SHALL have port Stall  input  1  freezes the sequencer for the cycle.
REQ-008 SHALL have port BranchEn  input  1  decoded branch instruction.
REQ-009 SHALL have port Cond  input  1  ALU condition flag; a branch is taken when BranchEn=1 and Cond=1.
REQ-010 SHALL have port JptrIn  input  5  jump-table index from the instruction field.
REQ-011 SHALL have port Jump  input  PC_W  target returned by the external jump lookup table.
REQ-012 SHALL have port CallEn  input  1  call instruction (used only under REQ-027).
REQ-013 SHALL have port RetEn  input  1  return instruction (used only under REQ-027).
REQ-014 SHALL have port Jptr  output  5  index driven to the jump lookup table.
REQ-015 SHALL have port ProgCtr  output  PC_W  current fetch address.
REQ-016 SHALL have port Done  output  1  high while the program is halted.

Function
REQ-017 SHALL implement states IDLE, RUN and DONE.
REQ-018 SHALL drive Jptr combinationally equal to JptrIn; Jump is combinational, and the target is applied at the same edge.
REQ-019 In IDLE, Start=1 SHALL load ProgCtr=START_ADDR and enter RUN at the next edge; all other inputs are ignored.
REQ-020 In RUN, update priority SHALL be Stall (hold all) > Halt (enter DONE, hold ProgCtr) > taken branch (ProgCtr<=Jump) > increment (ProgCtr<=ProgCtr+1).
REQ-021 Increment SHALL wrap modulo 2^PC_W (all-ones -> 0) with no flag.
REQ-022 BranchEn=1 with Cond=0 SHALL increment.
REQ-023 Start SHALL be ignored in RUN.
REQ-024 Done SHALL be registered: 1 exactly in DONE, 0 otherwise.
REQ-025 In DONE, Start=1 SHALL load ProgCtr=START_ADDR, clear Done and enter RUN at the next edge; otherwise all state holds.

Reset
REQ-026 Reset=1 SHALL immediately force IDLE, ProgCtr=START_ADDR, Done=0 and link register=0, including mid-RUN, overriding all inputs.

Configuration
REQ-027 With CALL_RET_EN defined: in RUN, below Halt and above branch in priority, CallEn=1 SHALL set link<=ProgCtr+1 and ProgCtr<=Jump; else RetEn=1 SHALL set ProgCtr<=link. The link register is one deep, and a second call overwrites it.
REQ-028 Without CALL_RET_EN: CallEn and RetEn SHALL remain as ports but be ignored, and no link register is built.

Structure
REQ-029 Package pc_pkg SHALL hold the PC_W default, START_ADDR default and the state enum (IDLE/RUN/DONE).
REQ-030 One combinational sub-module, pc_next, SHALL compute the next ProgCtr from the priority inputs; the state register lives in pc_sequencer.

Verification
REQ-031 Reset, then Start pulse -> ProgCtr 0,1,2,3 on successive edges; Done=0.
REQ-032 At PC=5: BranchEn=1, Cond=1, JptrIn=3, Jump=8 -> Jptr=3 same cycle, ProgCtr=8 next edge; the same stimulus with Cond=0 -> 6.
REQ-033 Stall and Halt both high at PC=9 -> PC holds 9 and the state stays RUN; Halt alone then gives DONE, Done=1, PC=9; Start -> PC=0, Done=0.
REQ-034 PC=4095, no branch -> PC=0; Reset asserted mid-RUN -> IDLE with PC=0 before the next edge.
REQ-035 CALL_RET_EN on: CallEn at PC=20 with Jump=100 -> PC=100; RetEn later -> PC=21. Macro off: same stimulus -> PC=21, then increments.
